// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator side of the word-addressed data memory. It accepts one load/store
// request at a time over a valid/ready handshake and turns the byte address
// into a word index. Sub-word stores are done as read-modify-write because the
// memory has no byte enables. Load data is lane-extracted and then sign- or
// zero-extended before it is returned on a valid/ready response channel.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_*                  request channel (valid/ready, write, size, unsigned, addr, wdata)
//   resp_*                 response channel (valid/ready, rdata, error)
//   mem_*                  data memory (address = word index, combinational read, write on posedge)
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses with an error response. Without it, the low offset bits are ignored.
//
// state  | meaning
// IDLE   | ready for a request
// READ   | memory read strobe; captures the load word or the word to be merged
// WRITE  | memory write strobe with the full or merged word
// RESP   | response held until resp_ready

module load_store_unit #(
    parameter  int MEM_WORDS = 32,
    localparam int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_input_data,
    output logic        mem_enable_read,
    output logic        mem_enable_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [IDX_W+1:0]  addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              error_q, error_d;

    logic              req_err;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    // Upper address bits wrap away by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:IDX_W+2];

    always_comb begin
        req_err = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_size == 2'b01 && req_addr[0]) ||
            (req_size == 2'b10 && req_addr[1:0] != 2'b00))
            req_err = 1'b1;
`endif
    end

    // Lane selection only ever looks at addr[1:0] (byte) or addr[1] (half),
    // so the non-trapping build naturally forces alignment.
    always_comb begin
        byte_lane = mem_read_data[8*addr_q[1:0] +: 8];
        half_lane = mem_read_data[16*addr_q[1] +: 16];
        case (size_q)
            2'b00:   load_val = unsigned_q ? {24'd0, byte_lane}
                                           : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_val = unsigned_q ? {16'd0, half_lane}
                                           : {{16{half_lane[15]}}, half_lane};
            default: load_val = mem_read_data;
        endcase
    end

    // data_q still holds the right-aligned store data while in READ.
    always_comb begin
        merged = mem_read_data;
        if (size_q == 2'b00)
            merged[8*addr_q[1:0] +: 8] = data_q[7:0];
        else
            merged[16*addr_q[1] +: 16] = data_q[15:0];
    end

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        error_d    = error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr[IDX_W+1:0];
                    data_d     = req_wdata;
                    rdata_d    = 32'd0;
                    error_d    = req_err;
                    if (req_err)
                        state_d = ST_RESP;
                    else if (req_write && req_size == 2'b10)
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (write_q) begin
                    data_d  = merged;
                    state_d = ST_WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (resp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= 32'd0;
            rdata_q    <= 32'd0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
        end
    end

    assign req_ready        = (state_q == ST_IDLE);
    assign resp_valid       = (state_q == ST_RESP);
    assign resp_error       = (state_q == ST_RESP) && error_q;
    assign resp_rdata       = (state_q == ST_RESP) ? rdata_q : 32'd0;
    assign mem_enable_read  = (state_q == ST_READ);
    assign mem_enable_write = (state_q == ST_WRITE);
    assign mem_address      = (state_q == ST_READ || state_q == ST_WRITE)
                              ? {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]} : 32'd0;
    assign mem_input_data   = (state_q == ST_WRITE) ? data_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int MEM_WORDS = 32;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_error;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata, mem_address, mem_input_data, mem_read_data;
    logic        mem_enable_read, mem_enable_write;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_error(resp_error),
        .mem_address(mem_address), .mem_input_data(mem_input_data),
        .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
        .mem_read_data(mem_read_data)
    );

    assign mem_read_data = mem[mem_address[4:0]];
    always @(posedge clk)
        if (mem_enable_write) mem[mem_address[4:0]] <= mem_input_data;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Spec-level model: one call per request, updates ref_mem for stores.
    function automatic void model_exec(input logic w, input logic [1:0] size,
                                       input logic uns, input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic err,
                                       output int lat);
        int idx, sh;
        logic [31:0] word, mask, v;
        idx  = int'(addr[6:2]);
        word = ref_mem[idx];
        rd   = 32'd0;
        err  = (size == 2'd3) ||
               (TRAP && ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)));
        if (err) begin
            lat = 1;
            return;
        end
        sh   = (size == 2'd0) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
        mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (size == 2'd2) sh = 0;
        if (w) begin
            ref_mem[idx] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
            lat = (size == 2'd2) ? 2 : 3;
        end else begin
            v = (word >> sh) & mask;
            if (!uns && size == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (!uns && size == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
            rd  = v;
            lat = 2;
        end
    endfunction

    task automatic run_req(input logic w, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                           output logic [31:0] rd, output logic err, output int lat,
                           output int wr_cnt, output int rd_cnt, output logic [31:0] wr_addr,
                           output logic stable_ok);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1; wr_cnt = 0; rd_cnt = 0; wr_addr = 32'd0;
        while (!resp_valid && lat < 20) begin
            if (mem_enable_write) begin wr_cnt++; wr_addr = mem_address; end
            if (mem_enable_read) rd_cnt++;
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata; err = resp_error; stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_error !== err || req_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) stable_ok = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(logic w, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] exp_rd, logic exp_err, int exp_lat);
        vec_t v;
        v.w = w; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    vec_t tbl[23];

    initial begin
        logic [31:0] rd, wa, erd;
        logic        err, ok, eerr;
        int          lat, wc, rc, elat, bad, hold;
        logic        w, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata;

        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'd0;

        tbl[0]  = mk(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
        tbl[1]  = mk(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);
        tbl[2]  = mk(1, 2'd2, 0, 32'h20, 32'h11223344, 32'h0, 0, 2);
        tbl[3]  = mk(1, 2'd0, 0, 32'h21, 32'hFFFFFFAA, 32'h0, 0, 3);
        tbl[4]  = mk(0, 2'd2, 0, 32'h20, 32'h0, 32'h1122AA44, 0, 2);
        tbl[5]  = mk(1, 2'd2, 0, 32'h00, 32'h80FF7F01, 32'h0, 0, 2);
        tbl[6]  = mk(0, 2'd0, 0, 32'h03, 32'h0, 32'hFFFFFF80, 0, 2);
        tbl[7]  = mk(0, 2'd1, 1, 32'h02, 32'h0, 32'h000080FF, 0, 2);
        tbl[8]  = mk(0, 2'd0, 0, 32'h01, 32'h0, 32'h0000007F, 0, 2);
        tbl[9]  = mk(0, 2'd1, 0, 32'h02, 32'h0, 32'hFFFF80FF, 0, 2);
        tbl[10] = mk(0, 2'd1, 0, 32'h00, 32'h0, 32'h00007F01, 0, 2);
        tbl[11] = mk(0, 2'd3, 0, 32'h04, 32'h0, 32'h0, 1, 1);
        tbl[12] = mk(1, 2'd3, 0, 32'h00, 32'h12345678, 32'h0, 1, 1);
        tbl[13] = mk(0, 2'd2, 0, 32'h00, 32'h0, 32'h80FF7F01, 0, 2);
        tbl[14] = mk(1, 2'd2, 0, 32'h04, 32'h55667788, 32'h0, 0, 2);
        tbl[15] = TRAP ? mk(0, 2'd2, 0, 32'h06, 32'h0, 32'h0, 1, 1)
                       : mk(0, 2'd2, 0, 32'h06, 32'h0, 32'h55667788, 0, 2);
        tbl[16] = TRAP ? mk(1, 2'd1, 0, 32'h07, 32'h0000BEEF, 32'h0, 1, 1)
                       : mk(1, 2'd1, 0, 32'h07, 32'h0000BEEF, 32'h0, 0, 3);
        tbl[17] = mk(0, 2'd2, 0, 32'h04, 32'h0, TRAP ? 32'h55667788 : 32'hBEEF7788, 0, 2);
        tbl[18] = mk(0, 2'd2, 0, 32'h90, 32'h0, 32'hDEADBEEF, 0, 2);
        tbl[19] = mk(0, 2'd0, 1, 32'h22, 32'h0, 32'h00000022, 0, 2);
        tbl[20] = mk(1, 2'd1, 0, 32'h22, 32'hCAFE1234, 32'h0, 0, 3);
        tbl[21] = mk(0, 2'd1, 0, 32'h20, 32'h0, 32'hFFFFAA44, 0, 2);
        tbl[22] = mk(0, 2'd2, 0, 32'h20, 32'h0, 32'h1234AA44, 0, 2);

        // Reset values
        #2;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid/error", {30'd0, resp_valid, resp_error}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset mem strobes", {30'd0, mem_enable_read, mem_enable_write}, 32'd0);
        check("reset mem_address", mem_address, 32'd0);
        check("reset mem_input_data", mem_input_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 23; i++) begin
            run_req(tbl[i].w, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, i % 3,
                    rd, err, lat, wc, rc, wa, ok);
            check($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d error", i), {31'd0, err}, {31'd0, tbl[i].exp_err});
            check($sformatf("tbl%0d latency", i), lat, tbl[i].exp_lat);
            check($sformatf("tbl%0d writes", i), wc, (tbl[i].w && !tbl[i].exp_err) ? 1 : 0);
            check($sformatf("tbl%0d reads", i), rc,
                  (!tbl[i].exp_err && !(tbl[i].w && tbl[i].size == 2'd2)) ? 1 : 0);
            if (tbl[i].w && !tbl[i].exp_err)
                check($sformatf("tbl%0d write addr", i), wa, {27'd0, tbl[i].addr[6:2]});
            check($sformatf("tbl%0d handshake", i), {31'd0, ok}, 32'd1);
        end

        // Held response: stability, ignored request, accept right after handshake
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h10;
        @(negedge clk);
        req_addr = 32'h20;
        @(negedge clk);
        check("hold first resp_valid", {31'd0, resp_valid}, 32'd1);
        check("hold first rdata", resp_rdata, 32'hDEADBEEF);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0 ||
                mem_enable_read !== 1'b0)
                bad++;
        end
        check("hold stable cycles bad", bad, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("hold idle after handshake", {30'd0, req_ready, resp_valid}, 32'd2);
        @(negedge clk);
        req_valid = 1'b0;
        check("hold next accepted read", {31'd0, mem_enable_read}, 32'd1);
        check("hold next address", mem_address, 32'd8);
        @(negedge clk);
        check("hold next rdata", resp_rdata, 32'h1234AA44);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // Reset during the read phase of a sub-word store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h21;
        req_wdata = 32'h55;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst-mid in READ", {31'd0, mem_enable_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst-mid req_ready", {31'd0, req_ready}, 32'd1);
        check("rst-mid strobes/resp", {28'd0, mem_enable_read, mem_enable_write, resp_valid, resp_error}, 32'd0);
        check("rst-mid mem_address", mem_address, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mem_enable_write !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        check("rst-mid no response", bad, 0);
        check("rst-mid memory unchanged", mem[8], 32'h1234AA44);

        // Randomized against the reference model
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = mem[i];
        for (int n = 0; n < 300; n++) begin
            w     = 1'($urandom);
            size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            uns   = 1'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            hold  = $urandom_range(0, 3);
            model_exec(w, size, uns, addr, wdata, erd, eerr, elat);
            run_req(w, size, uns, addr, wdata, hold, rd, err, lat, wc, rc, wa, ok);
            check($sformatf("rnd%0d rdata", n), rd, erd);
            check($sformatf("rnd%0d error", n), {31'd0, err}, {31'd0, eerr});
            check($sformatf("rnd%0d latency", n), lat, elat);
            check($sformatf("rnd%0d handshake", n), {31'd0, ok}, 32'd1);
        end
        for (int i = 0; i < MEM_WORDS; i++)
            check($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface: accepts load/store requests from the execute stage over a valid/ready handshake, drives the word-addressed data memory's `address`/`input_data`/`enable_read`/`enable_write` signals, and returns load data over a valid/ready response channel. It converts byte addresses to word indices. Sub-word stores use read-modify-write because the memory has no byte enables. Sub-word loads are extracted and sign- or zero-extended. It sits between the execute stage and the data memory.

## Interface
- `MEM_WORDS`, default 32: memory depth in 32-bit words; power of two; `IDX_W = $clog2(MEM_WORDS)`.
- `clk` in 1: clock; all state changes on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high exactly when FSM is in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes response.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_error` out 1: request rejected; no memory write performed.
- `mem_address` out 32: word index `req_addr[IDX_W+1:2]`, zero-extended; 0 when idle.
- `mem_input_data` out 32: write word; 0 when not writing.
- `mem_enable_read` out 1: memory read strobe. Memory read data is combinational.
- `mem_enable_write` out 1: memory write strobe. Memory writes on posedge.
- `mem_read_data` in 32: memory read data.

## Operation
- Request registered on acceptance (`req_valid && req_ready`). Request inputs are ignored otherwise.
- States: IDLE, READ, WRITE, RESP.
- IDLE to RESP with error set when size is 11, or when misaligned under `LSU_MISALIGN_TRAP_EN`. No memory access is made.
- IDLE to READ for a load or a sub-word store.
- IDLE to WRITE for a word store.
- READ: `mem_enable_read`=1 and `mem_address` driven.
  - `mem_read_data` is captured at the cycle-end edge.
  - A load goes to RESP.
  - A sub-word store goes to WRITE.
- WRITE: `mem_enable_write`=1.
  - For a word store, `mem_input_data` = wdata.
  - For a sub-word store, it is the captured word with the target lane replaced: byte lane = `addr[1:0]`, half lane = `addr[1]`.
  - Goes to RESP.
- RESP: `resp_valid`=1 with stable `resp_rdata`/`resp_error` until `resp_ready`. Then IDLE.
- Load extraction:
  - Byte = `word[8*addr[1:0] +: 8]`.
  - Half = `word[16*addr[1] +: 16]`.
  - Extend per `req_unsigned`.
- Address bits above `IDX_W+1` are ignored, so addresses wrap modulo `MEM_WORDS*4`.
- Only one request is outstanding; `req_ready`=0 from acceptance until the response handshake completes.

## Timing
- Request accepted in cycle N.
- Load and word store: memory access in N+1, `resp_valid` from N+2.
- Sub-word store: read in N+1, write in N+2, `resp_valid` from N+3.
- Error: `resp_valid` from N+1.
- Back-to-back: the next request can be accepted in the cycle after the response handshake (IDLE).
- Reset values:
  - State IDLE.
  - `req_ready`=1.
  - All `resp_*` and `mem_*` outputs 0.
  - Internal registers 0.
- Reset mid-operation: reset asserted before the WRITE-state posedge means no write occurs. The pending response is dropped. The FSM is IDLE immediately (asynchronous).
- `resp_ready` held high in RESP completes the handshake that cycle. `resp_ready` outside RESP is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half with `addr[0]`=1 is an error response (`resp_error`=1, `resp_rdata`=0, N+1, no access).
  - A word with `addr[1:0]`≠0 is likewise an error response.
- Not defined:
  - Low offset bits are forced aligned: half uses `addr[1]` only, word ignores `addr[1:0]`.
  - The access proceeds normally; `resp_error` is only for size 11.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10:
  - Store drives `mem_address`=4 and `mem_enable_write` in N+1.
  - Load returns `resp_rdata`=0xDEADBEEF, `resp_error`=0 in N+2.
- Preload 0x11223344 @0x20; byte store 0xAA @0x21:
  - Read in N+1, write 0x1122AA44 in N+2, response in N+3.
  - Subsequent word load returns 0x1122AA44.
- Memory word 0x80FF7F01 @0x0:
  - Signed byte load @0x3 returns 0xFFFFFF80.
  - Unsigned half load @0x2 returns 0x000080FF.
  - Signed byte load @0x1 returns 0x0000007F.
- Word load @0x6 with `LSU_MISALIGN_TRAP_EN`: `resp_error`=1 at N+1, no memory enable ever asserted. Without the macro: returns word index 1.
- Hold `resp_ready`=0 for 5 cycles after a load:
  - `resp_valid`/`resp_rdata` are stable throughout.
  - `req_ready` stays 0; `req_valid` is ignored.
  - Accept occurs the cycle after `resp_ready`=1.
- Assert `rst_n`=0 during the READ of a sub-word store:
  - Memory is unchanged.
  - All outputs go 0 immediately; `req_ready`=1.
  - No response is delivered.
